// File: rtl/gamepad_pkg.sv
// Shared definitions for the gamepad reader: FSM encoding, command byte,
// response length and a small sizing helper.
package gamepad_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        TX_BIT    = 3'd1,
        TX_STOP   = 3'd2,
        RX_WAIT   = 3'd3,
        RX_SAMPLE = 3'd4,
        RX_STOP   = 3'd5
    } gp_state_t;

    localparam logic [7:0] GP_CMD_BYTE  = 8'h01;
    localparam int         GP_RESP_BITS = 32;

    function automatic int gp_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/gamepad_bit_timer.sv
// Loadable down-counter that saturates at zero; done is high while the count is zero.
module gamepad_bit_timer #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic [W-1:0] o_count,
    output logic         o_done
);

    localparam logic [W-1:0] L_ONE = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] r_count;

    // Count register: load wins over decrement.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= {W{1'b0}};
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != {W{1'b0}}) begin
            r_count <= r_count - L_ONE;
        end else begin
            r_count <= r_count;
        end
    end

    assign o_count = r_count;
    assign o_done  = (r_count == {W{1'b0}});

endmodule

// File: rtl/gamepad_reader.sv
// Single-wire gamepad poller: sends the poll command, collects a 32-bit
// response and reports it, aborting with a timeout if the pad goes quiet.
module gamepad_reader
    import gamepad_pkg::*;
#(
    parameter int CLKS_PER_US   = 33,
    parameter int POLL_PERIOD   = 543750,
    parameter int RX_TIMEOUT_US = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        line_in,
    output logic        out_is_low,
    output logic [31:0] buttons,
    output logic        buttons_valid,
    output logic        timeout,
    output logic        busy
);

    localparam int TMAX = gp_max(4 * CLKS_PER_US, RX_TIMEOUT_US * CLKS_PER_US);
    localparam int TW   = $clog2(TMAX + 1);
    localparam int PW   = $clog2(POLL_PERIOD);

    localparam logic [TW-1:0] L_SLOT     = TW'(4 * CLKS_PER_US - 1);
    localparam logic [TW-1:0] L_STOP     = TW'(3 * CLKS_PER_US - 1);
    localparam logic [TW-1:0] L_HALF     = TW'(2 * CLKS_PER_US - 1);
    localparam logic [TW-1:0] L_TO       = TW'(RX_TIMEOUT_US * CLKS_PER_US - 1);
    // Low phase is active while the remaining count is at or above these marks.
    localparam logic [TW-1:0] L_LONG_LO  = TW'(CLKS_PER_US);
    localparam logic [TW-1:0] L_SHORT_LO = TW'(3 * CLKS_PER_US);
    localparam logic [TW-1:0] L_STOP_LO  = TW'(2 * CLKS_PER_US);
    localparam logic [PW-1:0] L_WRAP     = PW'(POLL_PERIOD - 1);
    localparam logic [PW-1:0] L_PONE     = PW'(1);
    localparam logic [5:0]    L_LAST_BIT = 6'(GP_RESP_BITS - 1);

    gp_state_t     r_state, w_state_nxt;
    logic [PW-1:0] r_poll_cnt;
    logic          r_sync1, r_sync2, r_sync_prev;
    logic [2:0]    r_bit_idx, w_bit_idx_nxt;
    logic [5:0]    r_rx_cnt, w_rx_cnt_nxt;
    logic [31:0]   r_shift, w_shift_nxt;
    logic          r_stop_seen, w_stop_seen_nxt;
    logic [31:0]   r_buttons, w_buttons_nxt;
    logic          r_valid, w_valid_nxt;
    logic          r_timeout, w_timeout_nxt;
    logic          r_out_low, w_out_low_nxt;
    logic          w_load;
    logic [TW-1:0] w_load_val, w_count;
    logic          w_done, w_wrap, w_fall, w_cur_bit;

    gamepad_bit_timer #(.W(TW)) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_count    (w_count),
        .o_done     (w_done)
    );

    assign w_wrap    = (r_poll_cnt == L_WRAP);
    assign w_fall    = r_sync_prev & ~r_sync2;
    assign w_cur_bit = GP_CMD_BYTE[r_bit_idx];

    // Poll counter, line synchronizer and edge-history flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_poll_cnt  <= {PW{1'b0}};
            r_sync1     <= 1'b1;
            r_sync2     <= 1'b1;
            r_sync_prev <= 1'b1;
        end else begin
            r_poll_cnt  <= w_wrap ? {PW{1'b0}} : (r_poll_cnt + L_PONE);
            r_sync1     <= line_in;
            r_sync2     <= r_sync1;
            r_sync_prev <= r_sync2;
        end
    end

    // Next-state logic for the poll sequence and the timer reloads.
    always_comb begin
        w_state_nxt     = r_state;
        w_load          = 1'b0;
        w_load_val      = L_TO;
        w_bit_idx_nxt   = r_bit_idx;
        w_rx_cnt_nxt    = r_rx_cnt;
        w_shift_nxt     = r_shift;
        w_stop_seen_nxt = r_stop_seen;
        w_buttons_nxt   = r_buttons;
        w_valid_nxt     = 1'b0;
        w_timeout_nxt   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_wrap && enable) begin
                    w_state_nxt   = TX_BIT;
                    w_load        = 1'b1;
                    w_load_val    = L_SLOT;
                    w_bit_idx_nxt = 3'd7;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            TX_BIT: begin
                if (w_done && (r_bit_idx == 3'd0)) begin
                    w_state_nxt = TX_STOP;
                    w_load      = 1'b1;
                    w_load_val  = L_STOP;
                end else if (w_done) begin
                    w_bit_idx_nxt = r_bit_idx - 3'd1;
                    w_load        = 1'b1;
                    w_load_val    = L_SLOT;
                end else begin
                    w_state_nxt = TX_BIT;
                end
            end
            TX_STOP: begin
                if (w_done) begin
                    w_state_nxt  = RX_WAIT;
                    w_load       = 1'b1;
                    w_load_val   = L_TO;
                    w_rx_cnt_nxt = 6'd0;
                end else begin
                    w_state_nxt = TX_STOP;
                end
            end
            RX_WAIT: begin
                if (w_fall) begin
                    w_state_nxt = RX_SAMPLE;
                    w_load      = 1'b1;
                    w_load_val  = L_HALF;
                end else if (w_done) begin
                    w_state_nxt   = IDLE;
                    w_timeout_nxt = 1'b1;
                end else begin
                    w_state_nxt = RX_WAIT;
                end
            end
            RX_SAMPLE: begin
                if (w_done) begin
                    w_shift_nxt = {r_shift[30:0], r_sync2};
                    w_load      = 1'b1;
                    w_load_val  = L_TO;
                    if (r_rx_cnt == L_LAST_BIT) begin
                        w_state_nxt     = RX_STOP;
                        w_stop_seen_nxt = 1'b0;
                    end else begin
                        w_state_nxt  = RX_WAIT;
                        w_rx_cnt_nxt = r_rx_cnt + 6'd1;
                    end
                end else begin
                    w_state_nxt = RX_SAMPLE;
                end
            end
            RX_STOP: begin
                if (!r_stop_seen && w_fall) begin
                    w_stop_seen_nxt = 1'b1;
                    w_load          = 1'b1;
                    w_load_val      = L_TO;
                end else if (r_stop_seen && r_sync2) begin
                    w_state_nxt   = IDLE;
                    w_buttons_nxt = r_shift;
                    w_valid_nxt   = 1'b1;
                end else if (w_done) begin
                    w_state_nxt   = IDLE;
                    w_timeout_nxt = 1'b1;
                end else begin
                    w_state_nxt = RX_STOP;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Line drive: only the low phases of the command and stop bits pull low.
    always_comb begin
        w_out_low_nxt = 1'b0;
        case (r_state)
            TX_BIT: begin
                if (w_cur_bit) begin
                    w_out_low_nxt = (w_count >= L_SHORT_LO);
                end else begin
                    w_out_low_nxt = (w_count >= L_LONG_LO);
                end
            end
            TX_STOP: w_out_low_nxt = (w_count >= L_STOP_LO);
            default: w_out_low_nxt = 1'b0;
        endcase
    end

    // FSM state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_bit_idx   <= 3'd0;
            r_rx_cnt    <= 6'd0;
            r_shift     <= 32'h0;
            r_stop_seen <= 1'b0;
            r_buttons   <= 32'h0;
            r_valid     <= 1'b0;
            r_timeout   <= 1'b0;
            r_out_low   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_bit_idx   <= w_bit_idx_nxt;
            r_rx_cnt    <= w_rx_cnt_nxt;
            r_shift     <= w_shift_nxt;
            r_stop_seen <= w_stop_seen_nxt;
            r_buttons   <= w_buttons_nxt;
            r_valid     <= w_valid_nxt;
            r_timeout   <= w_timeout_nxt;
            r_out_low   <= w_out_low_nxt;
        end
    end

    assign out_is_low    = r_out_low;
    assign buttons       = r_buttons;
    assign buttons_valid = r_valid;
    assign timeout       = r_timeout;
    assign busy          = (r_state != IDLE);

endmodule
